// File: rtl/hex_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_scan_pkg : segment types and the active-low hex decode table      |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
package hex_scan_pkg;

  typedef logic [6:0]        seg_t;
  typedef logic [15:0][6:0]  seg_table_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Element 0 is the rightmost entry; segment a is bit 0, active-low.
  localparam seg_table_t SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage
`default_nettype wire

// File: rtl/hex_scan_hex7seg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_scan_hex7seg : 4-bit nibble to active-low 7-segment decoder       |
// | Revision         : 1.0                                                |
// +----------------------------------------------------------------------+
module hex_scan_hex7seg
  import hex_scan_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = SEG_TABLE[nibble];

endmodule
`default_nettype wire

// File: rtl/hex_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_scan : multiplexed hex display scanner with LZ blanking and blink |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
module hex_scan
  import hex_scan_pkg::*;
#(
  parameter int NDIGITS      = 6,
  parameter int DIV          = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [4*NDIGITS-1:0]   value,
  input  logic                   load,
  input  logic                   lz_en,
  input  logic [NDIGITS-1:0]     blink_mask,
  output logic [6:0]             seg,
  output logic [NDIGITS-1:0]     an,
  output logic                   frame_tick
);

  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  if ((NDIGITS < 1) || (NDIGITS > 8)) begin : g_bad_ndigits
    $error("hex_scan: NDIGITS must be in 1..8");
  end
  if (DIV < 1) begin : g_bad_div
    $error("hex_scan: DIV must be 1 or greater");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("hex_scan: BLINK_FRAMES must be 1 or greater");
  end

  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [4*NDIGITS-1:0]   shadow_q, shadow_d;
  logic [FRM_W-1:0]       frm_q, frm_d;
  logic                   phase_q, phase_d;
  logic [6:0]             seg_q, seg_d;
  logic [NDIGITS-1:0]     an_q, an_d;
  logic                   frame_tick_q, frame_tick_d;

  logic                   slot_end;
  logic                   wrap;
  logic                   upper_zero;
  logic [NDIGITS-1:0]     lz_blank;
  logic [3:0]             nibble;
  logic                   digit_lz;
  logic                   digit_blink;
  seg_t                   dec_seg;

  always_comb begin
    slot_end     = (cnt_q == CNT_LAST);
    wrap         = slot_end && (idx_q == IDX_LAST);
    cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    if (slot_end) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end
    shadow_d     = load ? value : shadow_q;
    frame_tick_d = wrap;

    frm_d   = frm_q;
    phase_d = phase_q;
    if (wrap) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end

    // Walk from the top digit down so each digit knows whether all above it are zero.
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      upper_zero  = upper_zero && (shadow_d[4*i +: 4] == 4'h0);
      lz_blank[i] = lz_en && upper_zero && (i != 0);
    end

    nibble      = 4'h0;
    digit_lz    = 1'b0;
    digit_blink = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nibble      = shadow_d[4*i +: 4];
        digit_lz    = lz_blank[i];
        digit_blink = blink_mask[i];
      end
    end
  end

  hex_scan_hex7seg u_hex7seg (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    seg_d = (digit_lz || (phase_d && digit_blink)) ? SEG_BLANK : dec_seg;
    an_d  = ~(NDIGITS'(1) << idx_d);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      frm_q        <= '0;
      phase_q      <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      frm_q        <= frm_d;
      phase_q      <= phase_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire

// File: doc/hex_scan.md
HEX_SCAN -- requirements
Module: hex_scan

Interface
REQ-001 Parameter NDIGITS, default 6, sets the number of hex digits scanned; legal range 1..8.
REQ-002 Parameter DIV, default 50000, sets the clock cycles per digit slot; legal range is 1 or greater.
REQ-003 Parameter BLINK_FRAMES, default 64, sets the scan frames per blink half-period; legal range is 1 or greater.
REQ-004 clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-005 reset_n  input  1  reset, synchronous and active-low.
REQ-006 value  input  4*NDIGITS  digit i occupies bits [4i+3:4i]; digit 0 is the rightmost digit.
REQ-007 load  input  1  when high, value SHALL be captured into the shadow register at this edge.
REQ-008 lz_en  input  1  leading-zero blanking enable.
REQ-009 blink_mask  input  NDIGITS  bit i high makes digit i blink.
REQ-010 seg  output  7  segment drive, active-low, bit 0 = segment a … bit 6 = segment g.
REQ-011 an  output  NDIGITS  digit select, active-low, one-hot.
REQ-012 frame_tick  output  1  one-cycle pulse when the digit index wraps from NDIGITS-1 to 0.

Function
REQ-013 The prescaler SHALL count 0..DIV-1 and wrap; its terminal count SHALL be slot_end.
REQ-014 On slot_end the digit index SHALL increment, with wrap NDIGITS-1 -> 0; frame_tick SHALL be high in the cycle after that wrap edge.
REQ-015 seg and an SHALL be registered and SHALL reflect the new index and current shadow one cycle after the index changes.
REQ-016 load coinciding with an index change SHALL make the new shadow value the one displayed for the new slot.
REQ-017 Decode SHALL use the active-low map 0=40h 1=79h 2=24h 3=30h 4=19h 5=12h 6=02h 7=78h 8=00h 9=10h A=08h b=03h C=46h d=21h E=06h F=0Eh; blank=7Fh.
REQ-018 With lz_en high, digit i (i>0) SHALL be blank when it and every higher digit in the shadow are 0; digit 0 SHALL never be blanked by this rule.
REQ-019 The blink phase SHALL toggle after every BLINK_FRAMES frame_ticks; in phase 1, digits with their blink_mask bit set SHALL be blank. Phase 0 SHALL show them normally.
REQ-020 Blanking SHALL drive seg=7Fh only; an SHALL still select the digit.
REQ-021 When NDIGITS=1, an SHALL be 0 after reset; frame_tick SHALL pulse once per slot_end.
REQ-022 When DIV=1, the index SHALL advance every cycle.
REQ-023 lz_en and blink_mask SHALL be sampled combinationally, feeding the output register, with no extra latency.

Reset
REQ-024 While reset_n is low at an edge, the block SHALL set the prescaler, index, shadow, blink phase and frame counter to 0, seg to 7Fh, an to all ones, and frame_tick to 0.
REQ-025 Reset asserted mid-slot or mid-blink SHALL abort immediately; after release, the first slot SHALL be digit 0 with a full DIV count.
REQ-026 load SHALL be ignored while reset_n is low.

Structure
REQ-027 Package hex_scan_pkg SHALL hold the SEG_BLANK constant (7Fh) and the 16-entry segment table type and constant.
REQ-028 The block SHALL contain exactly one instance of the team's existing 4-bit hex7seg decoder, fed by the shadow nibble at the next index.
REQ-029 The RTL SHALL include elaboration-time checks for the parameter ranges in REQ-001 to REQ-003.

Verification
REQ-030 Reset: NDIGITS=6 and DIV=4 under reset -> seg=7Fh and an=3Fh; after release, an=3Eh with seg=40h (shadow 0).
REQ-031 Scan: load value=FEDCBAh with DIV=4 -> an walks 3Eh,3Dh,3Bh,37h,2Fh,1Fh, 4 cycles each, with seg 08h,03h,46h,21h,06h,0Eh; frame_tick pulses once per 24 cycles.
REQ-032 Leading zero: value=000120h with lz_en=1 -> digits 5..3 show 7Fh and digits 2..0 show 79h,24h,40h; value=0 -> only digit 0 shows 40h.
REQ-033 Blink: BLINK_FRAMES=2 with blink_mask=01h and value=888888h -> digit 0 shows 00h for 2 frames, then 7Fh for 2 frames, repeating; other digits stay at 00h.
REQ-034 Load on a slot boundary: load 111111h in the cycle with slot_end -> the next slot shows 79h.
REQ-035 Mid-scan reset: assert reset_n=0 for 1 cycle at index 3 -> outputs return to reset values at the next edge and the scan restarts at digit 0.
